// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the default-width beat record.
package aes_pkg;
  localparam int unsigned AES_BLOCK_W   = 128;
  localparam int unsigned AES128_NUM_RK = 11;
  localparam int unsigned AES256_NUM_RK = 15;
  localparam int unsigned AES_RK_IDX_W  = $clog2(AES256_NUM_RK);

  typedef struct packed {
    logic [AES_BLOCK_W-1:0]  text;
    logic [AES_RK_IDX_W-1:0] round;
    logic                    err;
  } aes_beat_t;
endpackage

// File: rtl/aes_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid register.
module aes_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iValid,
  output logic         oReady,
  input  logic [W-1:0] iData,
  output logic         oValid,
  input  logic         iReady,
  output logic [W-1:0] oData
);
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_xfer, out_xfer;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    skid_d   = skid_q;
    oValid   = (state_q != ST_EMPTY);
    oReady   = (state_q != ST_TWO);
    in_xfer  = iValid && oReady;
    out_xfer = oValid && iReady;
    unique case (state_q)
      ST_EMPTY: if (in_xfer) begin
        out_d   = iData;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        // accept-while-draining refills the output directly for 1 beat/cycle
        if (in_xfer && !out_xfer) begin
          skid_d  = iData;
          state_d = ST_TWO;
        end else if (in_xfer) begin
          out_d = iData;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (out_xfer) begin
        out_d   = skid_q;
        state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign oData = out_q;
endmodule

// File: rtl/round_key_adder_pipe.sv
// Round-key bank with registered XOR stage behind a 2-entry skid buffer.
module round_key_adder_pipe
  import aes_pkg::*;
#(
  parameter  int unsigned DATA_W   = AES_BLOCK_W,
  parameter  int unsigned NUM_KEYS = AES128_NUM_RK,
  localparam int unsigned IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                iClk,
  input  logic                iRsn,
  input  logic                iKeyWe,
  input  logic [IDX_W-1:0]    iKeyIdx,
  input  logic [DATA_W-1:0]   iKeyData,
  output logic [NUM_KEYS-1:0] oKeyLoaded,
  input  logic                iValid,
  output logic                oReady,
  input  logic [DATA_W-1:0]   iText,
  input  logic [IDX_W-1:0]    iRound,
  output logic                oValid,
  input  logic                iReady,
  output logic [DATA_W-1:0]   oRoundText,
  output logic [IDX_W-1:0]    oRound,
  output logic                oKeyErr
);
  typedef struct packed {
    logic [DATA_W-1:0] text;
    logic [IDX_W-1:0]  round;
    logic              err;
  } beat_t;

  logic [DATA_W-1:0]   key_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded_q, loaded_d;
  logic                wr_ok, rd_ok;
  logic [DATA_W-1:0]   rd_key;
  beat_t               in_beat, out_beat;

  always_comb begin
    wr_ok    = iKeyWe && (32'(iKeyIdx) < NUM_KEYS);
    loaded_d = loaded_q;
    if (wr_ok) loaded_d[iKeyIdx] = 1'b1;
    // read uses pre-edge bank state, so a same-edge write only affects later beats
    rd_ok    = (32'(iRound) < NUM_KEYS) && loaded_q[iRound];
    rd_key   = rd_ok ? key_q[iRound] : '0;
    in_beat  = '{text: iText ^ rd_key, round: iRound, err: !rd_ok};
  end

  always_ff @(posedge iClk) begin
    if (wr_ok) key_q[iKeyIdx] <= iKeyData;
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) loaded_q <= '0;
    else       loaded_q <= loaded_d;
  end

  aes_skid_buf #(
    .W ($bits(beat_t))
  ) u_skid (
    .iClk   (iClk),
    .iRsn   (iRsn),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (in_beat),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (out_beat)
  );

  assign oKeyLoaded = loaded_q;
  assign oRoundText = out_beat.text;
  assign oRound     = out_beat.round;
  assign oKeyErr    = out_beat.err;
endmodule
